// File: rtl/axis_pkg.sv
// axis_pkg: shared types for the AXI-Stream packet FIFO
package axis_pkg;
  typedef enum logic {ACCEPT, DROP} state_t;
endpackage

// File: rtl/axis_if.sv
// Axis_If: ready/valid/data/last stream bundle with master and slave views
interface Axis_If #(parameter int DWIDTH = 32);
  logic              ready;
  logic              valid;
  logic              last;
  logic [DWIDTH-1:0] data;
  modport Master_Full (output valid, data, last, input ready);
  modport Slave_Full  (input valid, data, last, output ready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: store-and-forward packet FIFO that drops packets longer than its storage
module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  Axis_If.Slave_Full               data_in,
  Axis_If.Master_Full              data_out,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic                     drop_pulse
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] W_DEPTH = PW'(DEPTH);
  logic [DWIDTH-1:0] r_data [DEPTH];
  logic              r_last [DEPTH];
  logic [PW-1:0]     r_rd_ptr, r_wr_commit, r_wr_spec, r_cnt;
  logic              r_drop, r_rdy_en;
  state_t            r_state, w_state_nx;
  logic              w_full, w_in_hs, w_out_hs, w_wr, w_commit, w_ovf, w_rd_last;
  logic [PW-1:0]     w_partial;
  assign w_full         = (r_wr_spec - r_rd_ptr) == W_DEPTH;
  assign w_partial      = r_wr_spec - r_wr_commit;
  assign data_in.ready  = r_rdy_en && (r_state == DROP || !w_full);
  assign w_in_hs        = data_in.valid && data_in.ready;
  assign w_wr           = w_in_hs && r_state == ACCEPT;
  assign w_commit       = w_wr && data_in.last;
  assign w_ovf          = w_wr && !data_in.last && (w_partial + PW'(1)) == W_DEPTH;
  assign data_out.valid = r_cnt != '0;
  assign data_out.data  = r_data[r_rd_ptr[AW-1:0]];
  assign data_out.last  = r_last[r_rd_ptr[AW-1:0]];
  assign w_out_hs       = data_out.valid && data_out.ready;
  assign w_rd_last      = w_out_hs && data_out.last;
  assign pkt_count      = r_cnt;
  assign drop_pulse     = r_drop;
  // next state: overflow enters DROP, the discarded packet's last beat returns to ACCEPT
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = (r_state == ACCEPT) ? (w_ovf ? DROP : ACCEPT)
                                     : ((w_in_hs && data_in.last) ? ACCEPT : DROP);
  end
  // state, pointers and packet count; ready stays low until the first edge out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ACCEPT;
      r_rd_ptr    <= '0;
      r_wr_commit <= '0;
      r_wr_spec   <= '0;
      r_cnt       <= '0;
      r_drop      <= 1'b0;
      r_rdy_en    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_wr_spec <= w_ovf ? r_wr_commit : (w_wr ? r_wr_spec + PW'(1) : r_wr_spec);
      if (w_commit) r_wr_commit <= r_wr_spec + PW'(1);
      if (w_out_hs) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_cnt    <= r_cnt + PW'(w_commit) - PW'(w_rd_last);
      r_drop   <= w_ovf;
      r_rdy_en <= 1'b1;
    end
  end
  // beat storage, not reset; a rolled-back beat is simply overwritten later
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_data[r_wr_spec[AW-1:0]] <= data_in.data;
      r_last[r_wr_spec[AW-1:0]] <= data_in.last;
    end
  end
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb_axis_pkt_fifo: directed and random packet traffic checked against a queue-based model
module tb_axis_pkt_fifo;
  localparam int DW  = 32;
  localparam int DEP = 16;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [$clog2(DEP):0] pkt_count;
  logic drop_pulse;
  Axis_If #(.DWIDTH(DW)) in_if ();
  Axis_If #(.DWIDTH(DW)) out_if ();
  axis_pkt_fifo #(.DWIDTH(DW), .DEPTH(DEP)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(in_if), .data_out(out_if),
    .pkt_count(pkt_count), .drop_pulse(drop_pulse)
  );
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_err = 0;
  logic [DW:0] q_out[$];
  logic [DW:0] q_part[$];
  logic [DW:0] src[$];
  int  npk = 0;
  bit  dropping = 0;
  bit  rdy_en = 0;
  bit  e_drop = 0;
  bit  in_hs, out_hs, out_rnd;
  int  drops_seen;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    q_out.delete(); q_part.delete();
    npk = 0; dropping = 0; rdy_en = 0; e_drop = 0;
  endtask
  task automatic tick();
    bit e_rdy, e_vld;
    logic [DW:0] b;
    @(negedge clk);
    e_rdy = rdy_en && (dropping || (q_out.size() + q_part.size() < DEP));
    e_vld = npk > 0;
    chk("in_ready", 64'(in_if.ready), 64'(e_rdy));
    chk("out_valid", 64'(out_if.valid), 64'(e_vld));
    chk("pkt_count", 64'(pkt_count), 64'(npk));
    chk("drop_pulse", 64'(drop_pulse), 64'(e_drop));
    if (e_vld) begin
      chk("out_data", 64'(out_if.data), 64'(q_out[0][DW-1:0]));
      chk("out_last", 64'(out_if.last), 64'(q_out[0][DW]));
    end
    if (drop_pulse) drops_seen++;
    in_hs  = in_if.valid && e_rdy;
    out_hs = e_vld && out_if.ready;
    b = {in_if.last, in_if.data};
    @(posedge clk);
    if (!reset_n) model_clear();
    else begin
      e_drop = 0;
      if (out_hs) begin
        if (q_out[0][DW]) npk--;
        void'(q_out.pop_front());
      end
      if (in_hs) begin
        if (dropping) dropping = !b[DW];
        else begin
          q_part.push_back(b);
          if (b[DW]) begin
            foreach (q_part[i]) q_out.push_back(q_part[i]);
            q_part.delete();
            npk++;
          end else if (q_part.size() == DEP) begin
            q_part.delete();
            dropping = 1;
            e_drop = 1;
          end
        end
      end
      rdy_en = 1;
    end
    #1;
  endtask
  task automatic run(input int n, input int pv);
    for (int i = 0; i < n; i++) begin
      in_if.valid = src.size() > 0 && $urandom_range(99) < pv;
      in_if.data  = src.size() > 0 ? src[0][DW-1:0] : '0;
      in_if.last  = src.size() > 0 ? src[0][DW] : 1'b0;
      if (out_rnd) out_if.ready = $urandom_range(1);
      tick();
      if (in_hs) void'(src.pop_front());
    end
    in_if.valid = 1'b0;
  endtask
  task automatic push_pkt(input int len, input bit seq);
    for (int i = 1; i <= len; i++) src.push_back({i == len, seq ? DW'(i) : DW'($urandom)});
  endtask
  initial begin
    in_if.valid = 0; in_if.data = '0; in_if.last = 0;
    out_if.ready = 1; out_rnd = 0;
    model_clear();
    run(3, 100);
    #2 reset_n = 1;
    run(2, 100);
    push_pkt(5, 1);
    run(15, 100);
    drops_seen = 0;
    push_pkt(20, 1);
    run(30, 100);
    chk("oversize_drops", 64'(drops_seen), 64'd1);
    out_if.ready = 0;
    push_pkt(16, 1);
    run(20, 100);
    chk("exact_fit_count", 64'(pkt_count), 64'd1);
    out_if.ready = 1;
    run(20, 100);
    out_if.ready = 0;
    push_pkt(8, 0);
    push_pkt(10, 0);
    run(25, 100);
    chk("bp_left", 64'(src.size()), 64'd2);
    out_if.ready = 1;
    run(30, 100);
    out_if.ready = 0;
    push_pkt(3, 0);
    run(5, 100);
    push_pkt(2, 0);
    src[1][DW] = 1'b0;
    run(4, 100);
    out_if.ready = 1;
    run(2, 100);
    src.push_back({1'b1, DW'($urandom)});
    run(1, 100);
    chk("simul_last_count", 64'(pkt_count), 64'd1);
    run(10, 100);
    push_pkt(6, 0);
    run(3, 100);
    reset_n = 0;
    src.delete();
    model_clear();
    run(2, 100);
    chk("reset_count", 64'(pkt_count), 64'd0);
    reset_n = 1;
    run(1, 100);
    push_pkt(2, 0);
    run(8, 100);
    out_rnd = 1;
    for (int p = 0; p < 60; p++) begin
      push_pkt($urandom_range(1, 20), 0);
      run($urandom_range(5, 40), 75);
    end
    out_rnd = 0;
    out_if.ready = 1;
    run(200, 100);
    chk("drain_count", 64'(pkt_count), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
